fifo_tx_sched: RTL and testbench

Controller that sequences the 8-bit bridge FIFO between the I2C receive side and the UART transmit side. It owns the FIFO write/read enables and tracks occupancy internally, because the FIFO exposes only underflow/overflow flags. It pops bytes and presents them to the UART transmitter over a valid/ready handshake. It also provides back-pressure to the writer and a flush command.

---
 rtl/fifo_sched_pkg.sv | 24 ++
 rtl/fifo_occ_counter.sv | 43 ++++
 rtl/fifo_tx_sched.sv | 178 +++++++++++++++++
 tb/tb_fifo_tx_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sched_pkg
// Shared types and helpers for the bridge FIFO transmit scheduler.
//   sched_state_t : scheduler FSM states
//   DATA_W_DEF    : default byte width
//   cnt_width()   : width of an occupancy counter able to hold 0..depth
// -----------------------------------------------------------------------------
package fifo_sched_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_FLUSH   = 3'd4
    } sched_state_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_occ_counter.sv
// -----------------------------------------------------------------------------
// fifo_occ_counter
// Up/down occupancy counter for a FIFO controller, with empty/full decode.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_inc            : an entry was written this cycle
//   i_dec            : an entry was popped this cycle
//   o_count          : current occupancy (0..DEPTH)
//   o_empty, o_full  : count==0, count==DEPTH
// The caller guarantees no increment while full and no decrement while empty.
// -----------------------------------------------------------------------------
module fifo_occ_counter
    import fifo_sched_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_inc && !i_dec) begin
            r_count <= r_count + CNT_W'(1);
        end else if (i_dec && !i_inc) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/fifo_tx_sched.sv
// -----------------------------------------------------------------------------
// fifo_tx_sched
// Sequences the 8-bit bridge FIFO between the I2C receive side and the UART
// transmitter. Owns the FIFO enables, tracks occupancy itself, pops bytes and
// offers them to the UART over valid/ready, back-pressures the writer and
// services a flush request.
// Ports:
//   i_clk, i_reset_n            : clock, asynchronous active-low reset
//   i_wr_valid/i_wr_data        : writer offer
//   o_wr_ready                  : space available and not flushing
//   o_fifo_en_write/o_fifo_data : FIFO write side (combinational pass-through)
//   o_fifo_en_read              : FIFO pop (registered)
//   i_fifo_data                 : FIFO read data, valid the cycle after a pop
//   i_fifo_underflow/overflow   : FIFO consistency flags
//   i_flush                     : single-cycle request to discard contents
//   o_tx_valid/o_tx_data/i_tx_ready : UART handshake
//   o_count/o_empty/o_full      : occupancy
//   o_error                     : sticky FIFO-flag alarm
// Optional build macro FIFO_SCHED_STATS_EN adds:
//   o_drop_cnt : saturating count of cycles a write was refused
//   o_tx_cnt   : wrapping count of completed UART handshakes
// -----------------------------------------------------------------------------
module fifo_tx_sched
    import fifo_sched_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr_valid,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    output logic              o_fifo_en_write,
    output logic [DATA_W-1:0] o_fifo_data,
    output logic              o_fifo_en_read,
    input  logic [DATA_W-1:0] i_fifo_data,
    input  logic              i_fifo_underflow,
    input  logic              i_fifo_overflow,
    input  logic              i_flush,
    output logic              o_tx_valid,
    output logic [DATA_W-1:0] o_tx_data,
    input  logic              i_tx_ready,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_error
`ifdef FIFO_SCHED_STATS_EN
    ,
    output logic [15:0]       o_drop_cnt,
    output logic [15:0]       o_tx_cnt
`endif
);

    sched_state_t      r_state;
    sched_state_t      w_state_next;
    logic              r_fifo_en_read;
    logic              w_en_read_next;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_flush_pending;
    logic              w_flush_clr;
    logic              r_error;

    logic              w_wr_ready;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_full;

    assign w_wr_ready = !w_full && (r_state != ST_FLUSH);
    assign w_push     = i_wr_valid && w_wr_ready;
    // The registered read enable is the pop itself: it is only raised for
    // READ or FLUSH cycles, both of which are entered with count>0.
    assign w_pop      = r_fifo_en_read;

    fifo_occ_counter #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_occ (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (w_push),
        .i_dec     (w_pop),
        .o_count   (w_count),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    always_comb begin
        w_state_next = r_state;
        w_flush_clr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_flush_pending) begin
                    w_flush_clr = 1'b1;
                    if (!w_empty) begin
                        w_state_next = ST_FLUSH;
                    end
                end else if (!w_empty) begin
                    w_state_next = ST_READ;
                end
            end
            ST_READ:    w_state_next = ST_CAPTURE;
            ST_CAPTURE: w_state_next = ST_SEND;
            ST_SEND: begin
                if (i_tx_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // Writes are blocked here, so count only falls; the pop issued
                // while count==1 empties the FIFO.
                if (w_count == CNT_W'(1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        w_en_read_next = (w_state_next == ST_READ) || (w_state_next == ST_FLUSH);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= ST_IDLE;
            r_fifo_en_read  <= 1'b0;
            r_tx_data       <= '0;
            r_flush_pending <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_fifo_en_read <= w_en_read_next;
            if (r_state == ST_CAPTURE) begin
                r_tx_data <= i_fifo_data;
            end
            // A new request wins over the clear so a pulse is never lost.
            r_flush_pending <= i_flush || (r_flush_pending && !w_flush_clr);
            if (i_fifo_underflow || i_fifo_overflow) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_wr_ready      = w_wr_ready;
    assign o_fifo_en_write = w_push;
    assign o_fifo_data     = i_wr_data;
    assign o_fifo_en_read  = r_fifo_en_read;
    assign o_tx_valid      = (r_state == ST_SEND);
    assign o_tx_data       = r_tx_data;
    assign o_count         = w_count;
    assign o_empty         = w_empty;
    assign o_full          = w_full;
    assign o_error         = r_error;

`ifdef FIFO_SCHED_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [15:0] r_tx_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_drop_cnt <= '0;
            r_tx_cnt   <= '0;
        end else begin
            if (i_wr_valid && !w_wr_ready && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (o_tx_valid && i_tx_ready) begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end
        end
    end

    assign o_drop_cnt = r_drop_cnt;
    assign o_tx_cnt   = r_tx_cnt;
`endif

endmodule

// File: tb/tb_fifo_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_fifo_tx_sched
// Directed bench for fifo_tx_sched with a behavioural FIFO model. Expected UART
// bytes are queued as stimulus is issued; a negedge monitor pops and compares
// on every handshake. Build with FIFO_SCHED_STATS_EN to cover the counters.
// -----------------------------------------------------------------------------
module tb_fifo_tx_sched;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          fifo_en_write;
    logic [DW-1:0] fifo_wdata;
    logic          fifo_en_read;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_uf;
    logic          fifo_of;
    logic          flush;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          error;
`ifdef FIFO_SCHED_STATS_EN
    logic [15:0]   drop_cnt;
    logic [15:0]   tx_cnt;
`endif

    always #5 clk = ~clk;

    fifo_tx_sched #(.DEPTH(DEPTH), .DATA_W(DW), .CNT_W(CW)) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_wr_valid       (wr_valid),
        .i_wr_data        (wr_data),
        .o_wr_ready       (wr_ready),
        .o_fifo_en_write  (fifo_en_write),
        .o_fifo_data      (fifo_wdata),
        .o_fifo_en_read   (fifo_en_read),
        .i_fifo_data      (fifo_rdata),
        .i_fifo_underflow (fifo_uf),
        .i_fifo_overflow  (fifo_of),
        .i_flush          (flush),
        .o_tx_valid       (tx_valid),
        .o_tx_data        (tx_data),
        .i_tx_ready       (tx_ready),
        .o_count          (count),
        .o_empty          (empty),
        .o_full           (full),
        .o_error          (error)
`ifdef FIFO_SCHED_STATS_EN
        ,
        .o_drop_cnt       (drop_cnt),
        .o_tx_cnt         (tx_cnt)
`endif
    );

    int            nchecks = 0;
    int            nfail   = 0;
    logic [DW-1:0] sbq[$];
    logic [DW-1:0] mon_exp;
    int            exp_tx_total = 0;
    int            cyc = 0;
    int            rd_pulses = 0;
    int            rd_first = -1;
    int            rd_last = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end else begin
            $display("ok   %s value=0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DW-1:0] b);
        sbq.push_back(b);
        exp_tx_total++;
    endtask

    task automatic wait_tx_valid(input string name, input int limit);
        for (int i = 0; i < limit && !tx_valid; i++) tick();
        check(name, 32'(tx_valid), 32'd1);
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int i = 0; i < limit && !(sbq.size() == 0 && count == '0 && !tx_valid); i++) tick();
        check(name, 32'(sbq.size() == 0 && count == '0 && !tx_valid), 32'd1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural bridge FIFO: pop data appears the cycle after the enable.
    logic [DW-1:0] fq[$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            fifo_rdata <= '0;
            fifo_uf    <= 1'b0;
            fifo_of    <= 1'b0;
        end else begin
            fifo_uf <= 1'b0;
            fifo_of <= 1'b0;
            if (fifo_en_read) begin
                if (fq.size() == 0) fifo_uf <= 1'b1;
                else                fifo_rdata <= fq.pop_front();
            end
            if (fifo_en_write) begin
                if (fq.size() >= DEPTH) fifo_of <= 1'b1;
                else                    fq.push_back(fifo_wdata);
            end
        end
    end

    // Monitor: read-pulse accounting and scoreboard compare on handshakes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_en_read) begin
                rd_pulses++;
                if (rd_first < 0) rd_first = cyc;
                rd_last = cyc;
            end
            if (tx_valid && tx_ready) begin
                if (sbq.size() == 0) begin
                    nchecks++;
                    nfail++;
                    $display("FAIL tx_unexpected actual=0x%0h required=none", tx_data);
                end else begin
                    mon_exp = sbq.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        flush    = 1'b0;
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_en_read", 32'(fifo_en_read), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Single byte latency: write in N, pop in N+2, valid in N+4.
        tx_ready = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        push_exp(8'hA5);
        #1;
        check("lat_en_write", 32'(fifo_en_write), 32'd1);
        check("lat_fifo_data", 32'(fifo_wdata), 32'hA5);
        tick();                                  // N+1
        wr_valid = 1'b0;
        check("lat_n1_count", 32'(count), 32'd1);
        check("lat_n1_en_read", 32'(fifo_en_read), 32'd0);
        tick();                                  // N+2
        check("lat_n2_en_read", 32'(fifo_en_read), 32'd1);
        tick();                                  // N+3
        check("lat_n3_en_read", 32'(fifo_en_read), 32'd0);
        check("lat_n3_tx_valid", 32'(tx_valid), 32'd0);
        tick();                                  // N+4
        check("lat_n4_tx_valid", 32'(tx_valid), 32'd1);
        check("lat_n4_tx_data", 32'(tx_data), 32'hA5);
        tick();                                  // N+5
        check("lat_n5_tx_valid", 32'(tx_valid), 32'd0);
        check("lat_n5_count", 32'(count), 32'd0);

        // Fill: the first byte is popped into the UART holding register, so
        // 17 writes leave 16 entries in the FIFO.
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            push_exp(8'(i));
            tick();
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_wr_ready", 32'(wr_ready), 32'd0);
        check("fill_count", 32'(count), 32'd16);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h11;
            #1;
            check("fill_blocked_write", 32'(fifo_en_write), 32'd0);
            tick();
        end
        wr_valid = 1'b0;
        check("fill_count_hold", 32'(count), 32'd16);
        tx_ready = 1'b1;
        wait_drain("fill_drain", 300);
        check("fill_error", 32'(error), 32'd0);

        // Write coinciding with a READ pop at count=5.
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h40 + i);
            push_exp(8'(8'h40 + i));
            tick();
        end
        wr_valid = 1'b0;
        wait_tx_valid("simul_send", 20);
        check("simul_count_pre", 32'(count), 32'd5);
        tx_ready = 1'b1;
        tick();                                  // IDLE
        tx_ready = 1'b0;
        tick();                                  // READ
        check("simul_en_read", 32'(fifo_en_read), 32'd1);
        wr_valid = 1'b1;
        wr_data  = 8'h46;
        push_exp(8'h46);
        tick();
        wr_valid = 1'b0;
        check("simul_count", 32'(count), 32'd5);
        tx_ready = 1'b1;
        wait_drain("simul_drain", 100);

        // Flush requested during SEND.
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h60 + i);
            tick();
        end
        wr_valid = 1'b0;
        push_exp(8'h60);
        wait_tx_valid("flush_send", 20);
        check("flush_count_pre", 32'(count), 32'd9);
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        rd_pulses = 0;
        rd_first  = -1;
        rd_last   = -1;
        tick();
        check("flush_send_held", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1;                         // handshake this cycle
        tick();                                  // IDLE
        tick();                                  // first FLUSH cycle
        check("flush_en_read", 32'(fifo_en_read), 32'd1);
        check("flush_wr_ready", 32'(wr_ready), 32'd0);
        wait_drain("flush_drain", 100);
        repeat (3) tick();
        check("flush_pulses", 32'(rd_pulses), 32'd9);
        check("flush_consecutive", 32'(rd_last - rd_first + 1), 32'd9);
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_wr_ready_after", 32'(wr_ready), 32'd1);
        check("error_clear", 32'(error), 32'd0);

`ifdef FIFO_SCHED_STATS_EN
        check("stats_drop_cnt", 32'(drop_cnt), 32'd3);
        check("stats_tx_cnt", 32'(tx_cnt), 32'(exp_tx_total));
`endif

        // Asynchronous reset while a byte waits in SEND: the byte is dropped.
        tx_ready = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        tick();
        wr_valid = 1'b0;
        wait_tx_valid("arst_send", 20);
        rst_n = 1'b0;
        #1;
        check("arst_tx_valid", 32'(tx_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_tx_data", 32'(tx_data), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
